// File: rtl/img_frame_writer.sv
// img_frame_writer
// Sink end of the pixel byte stream. Bytes arrive over valid/ready, sit in a
// small FIFO so short memory stalls do not back-pressure the pixel stage, and
// are written sequentially into the frame buffer starting at the byte that
// carries start-of-frame. Line and frame boundaries are reported as pulses; a
// start-of-frame seen in the middle of a frame restarts the frame at address 0
// and raises a sticky error flag.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for a start-of-frame byte; non-sof bytes are discarded
// S_WRITE | writing FIFO head bytes to memory, one per accepted write
// S_DONE  | one-cycle frame_done pulse, FIFO keeps filling but is not popped

module img_frame_writer #(
  parameter int FRAME_BYTES = 98304,
  parameter int LINE_BYTES  = 768,
  parameter int ADDR_W      = 17,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_sof,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  input  logic              i_mem_ready,
  output logic              o_line_end,
  output logic              o_frame_done,
  output logic              o_busy,
  output logic              o_err_resync,
  input  logic              i_err_clr
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int LW = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;

  localparam logic [CW-1:0]     FIFO_FULL  = CW'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_BYTES - 1);
  localparam logic [LW-1:0]     LAST_LPOS  = LW'(LINE_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // FIFO storage: each entry is {sof, data}
  logic [8:0]        r_fifo [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_in_ready;

  // FSM / frame tracking
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LW-1:0]     r_lpos;
  logic              r_err_resync;
  logic              r_frame_done;
  logic              r_line_end;

  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_count_nxt;
  logic [8:0]        w_head;
  logic              w_head_valid;
  logic              w_head_sof;
  logic              w_mem_we;
  logic              w_wr_done;
  logic              w_resync;
  logic [ADDR_W-1:0] w_eff_addr;
  logic [LW-1:0]     w_eff_lpos;

  assign w_push       = i_in_valid && r_in_ready;
  assign w_head       = r_fifo[r_rd_ptr];
  assign w_head_valid = (r_count != '0);
  assign w_head_sof   = w_head[8];

  // Next FIFO occupancy; push and pop together leave it unchanged
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Write-side decode: a sof at the head always lands at address 0, which
  // both starts a normal frame and restarts a frame on resync
  always_comb begin
    w_mem_we   = (r_state == S_WRITE) && w_head_valid;
    w_wr_done  = w_mem_we && i_mem_ready;
    w_eff_addr = w_head_sof ? '0 : r_addr;
    w_eff_lpos = w_head_sof ? '0 : r_lpos;
    w_resync   = w_mem_we && w_head_sof && (r_addr != '0);
    w_pop      = w_wr_done ||
                 ((r_state == S_IDLE) && w_head_valid && !w_head_sof);
  end

  // FIFO pointers, storage and registered ready (ready only from occupancy,
  // so a full FIFO never takes a byte even when it is popped that cycle)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= {i_in_sof, i_in_data};
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != FIFO_FULL);
    end
  end

  // Frame sequencing FSM with address / line-position counters and flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_lpos       <= '0;
      r_err_resync <= 1'b0;
      r_frame_done <= 1'b0;
      r_line_end   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_line_end   <= 1'b0;

      // a new resync event takes priority over a clear in the same cycle
      if (w_resync) begin
        r_err_resync <= 1'b1;
      end else if (i_err_clr) begin
        r_err_resync <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_head_valid && w_head_sof) begin
            r_state <= S_WRITE;
            r_addr  <= '0;
            r_lpos  <= '0;
          end
        end
        S_WRITE: begin
          if (w_wr_done) begin
            r_line_end <= (w_eff_lpos == LAST_LPOS);
            if (w_eff_addr == LAST_ADDR) begin
              r_state      <= S_DONE;
              r_addr       <= '0;
              r_lpos       <= '0;
              r_frame_done <= 1'b1;
            end else begin
              r_addr <= w_eff_addr + ADDR_W'(1);
              r_lpos <= (w_eff_lpos == LAST_LPOS) ? '0 : (w_eff_lpos + LW'(1));
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_mem_we     = w_mem_we;
  assign o_mem_addr   = w_eff_addr;
  assign o_mem_wdata  = w_head[7:0];
  assign o_line_end   = r_line_end;
  assign o_frame_done = r_frame_done;
  assign o_busy       = (r_state == S_WRITE);
  assign o_err_resync = r_err_resync;

endmodule

// File: doc/img_frame_writer.md
Name: img_frame_writer

Overview:
- Sink end of the pixel-processing byte stream: accepts processed bytes from the point-operation stage via valid/ready and writes them sequentially into a frame buffer memory port.
- Default frame is 256x128 RGB = 98304 bytes, with 768 bytes per line.
- Buffers up to FIFO_DEPTH bytes so memory stalls do not immediately back-pressure the pixel stage.
- Reports line and frame boundaries and start-of-frame resynchronisation errors.

Parameters:
FRAME_BYTES, 98304, bytes per frame; last address written is FRAME_BYTES-1
LINE_BYTES, 768, bytes per line; must divide FRAME_BYTES
ADDR_W, 17, memory address width; 2^ADDR_W >= FRAME_BYTES
FIFO_DEPTH, 4, input buffer entries; power of two, >= 2

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous active-high reset
in_data  in  8  processed pixel byte
in_sof  in  1  marks first byte of a frame; qualified by in_valid
in_valid  in  1  byte present
in_ready  out  1  block can accept; transfer when in_valid && in_ready
mem_we  out  1  write request
mem_addr  out  ADDR_W  write address
mem_wdata  out  8  write data
mem_ready  in  1  memory accepts write; write completes when mem_we && mem_ready
line_end  out  1  one-cycle pulse on completion of last byte of each line
frame_done  out  1  one-cycle pulse after final byte of frame written
busy  out  1  high in WRITE state
err_resync  out  1  sticky: sof arrived mid-frame
err_clr  in  1  synchronous clear of err_resync

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values:
  - All outputs 0 while rst is high, including in_ready.
  - FIFO empty; address counter 0; state IDLE.
  - Reset mid-frame abandons the frame; no frame_done is generated.
- FIFO:
  - Entries are 9 bits {sof, data}.
  - in_ready = !full, registered from count. No write-through when full, even with a simultaneous pop.
  - Simultaneous push and pop leaves count unchanged.
  - Head entry is registered: a byte accepted at edge N is at the head from cycle N+1.
- States IDLE, WRITE, DONE:
  - IDLE, head valid, sof=0: entry popped and discarded; no memory write; no error.
  - IDLE, head valid, sof=1: go to WRITE; entry not popped; address = 0.
  - WRITE: mem_we = head valid; mem_wdata = head data; mem_addr = address counter.
    - On mem_we && mem_ready: pop the entry and increment the address.
    - mem_we, mem_addr and mem_wdata are held stable while mem_ready is low.
  - WRITE, completion of the write at FRAME_BYTES-1: go to DONE; address returns to 0.
  - DONE: frame_done=1 for exactly one cycle; go to IDLE. No pop in DONE; bytes keep filling the FIFO.
- Resync:
  - In WRITE, a head entry with sof=1 while the address counter != 0 sets err_resync.
  - That byte is written at address 0 (mem_addr forced to 0 combinationally) and the address counter continues from 1.
  - The previous partial frame is abandoned without frame_done.
- line_end pulses in the cycle after a completed write whose address mod LINE_BYTES == LINE_BYTES-1. It coincides with the DONE cycle for the last line.
- err_resync and err_clr:
  - err_clr clears err_resync.
  - If a set event and err_clr occur in the same cycle, set wins.
- Latency: sof byte accepted at edge N gives earliest mem_we at cycle N+2. Subsequent bytes need no extra cycle, so throughput is 1 byte/clk when mem_ready stays high.
- busy = (state == WRITE).

Test Plan:
Use FRAME_BYTES=12, LINE_BYTES=4, FIFO_DEPTH=4, ADDR_W=4.
- Basic frame: bytes 0x10..0x1B back-to-back, sof on 0x10, mem_ready=1 -> writes addr 0..11 with data 0x10..0x1B; line_end after addr 3, 7, 11; frame_done 1 cycle after addr 11; err_resync=0.
- Leading garbage: 0xAA, 0xBB (sof=0), then a 12-byte sof frame -> 0xAA and 0xBB never written; frame lands at addr 0..11.
- Back-pressure: mem_ready low for 10 cycles after the 2nd write -> in_ready drops after 4 further bytes accepted; mem_we/addr/data held stable; no byte lost or duplicated; final memory matches input.
- Resync: sof frame, 5 bytes, then new sof byte 0x55 -> err_resync=1; 0x55 written at addr 0; next byte at addr 1; no frame_done for the first frame; err_clr pulse -> err_resync=0.
- Reset mid-frame: assert rst asynchronously after 6 writes -> outputs 0 immediately; after release, in_ready=1, FIFO empty, next sof frame writes from addr 0.
- Set/clear collision: err_clr high in the same cycle as a resync event -> err_resync=1.
